// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold sequencer: arbitrates jump/interrupt/execute/bus requests into PC/IF/ID hold enables.
// Optional stalled-cycle performance counter built only when PIPE_HOLD_CTRL_PERF_EN is defined.
module pipe_hold_ctrl #(
    parameter int unsigned DW            = 32,
    parameter int unsigned FLUSH_CYC     = 2,
    parameter int unsigned STALL_TIMEOUT = 1024,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jump_req_i,
    input  logic [DW-1:0]    jump_addr_i,
    input  logic             hold_clint_i,
    input  logic             hold_ex_i,
    input  logic             hold_bus_i,
    output logic             jump_flag_o,
    output logic [DW-1:0]    jump_addr_o,
    output logic             hold_pc_o,
    output logic             hold_if_o,
    output logic             hold_id_o,
    output logic             stall_err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int unsigned FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam int unsigned WD_W = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t          state;
    logic [FC_W-1:0] flush_cnt;
    logic [WD_W-1:0] wd_cnt;
    logic            any_hold_c;
    logic            full_hold_c;

    assign any_hold_c  = hold_clint_i | hold_ex_i | hold_bus_i;
    assign full_hold_c = hold_clint_i | hold_ex_i;

    // Sequencer: jump always wins; stall requests are only looked at outside an active flush.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= RUN;
            flush_cnt   <= '0;
            jump_flag_o <= 1'b0;
            jump_addr_o <= '0;
            hold_pc_o   <= 1'b0;
            hold_if_o   <= 1'b0;
            hold_id_o   <= 1'b0;
        end else begin
            jump_flag_o <= 1'b0;
            if (jump_req_i) begin
                state       <= FLUSH;
                flush_cnt   <= FC_W'(FLUSH_CYC - 1);
                jump_addr_o <= jump_addr_i;
                jump_flag_o <= 1'b1;
                hold_pc_o   <= 1'b0;
                hold_if_o   <= 1'b1;
                hold_id_o   <= 1'b1;
            end else if (state == FLUSH && flush_cnt != '0) begin
                flush_cnt <= flush_cnt - FC_W'(1);
            end else begin
                state     <= any_hold_c ? STALL : RUN;
                hold_pc_o <= any_hold_c;
                hold_if_o <= any_hold_c;
                hold_id_o <= full_hold_c;
            end
        end
    end

    // Watchdog: counts consecutive STALL cycles and latches a sticky error at the timeout.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_cnt      <= '0;
            stall_err_o <= 1'b0;
        end else if (state == STALL) begin
            if (wd_cnt == WD_W'(STALL_TIMEOUT - 1)) begin
                stall_err_o <= 1'b1;
            end else begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
        end else begin
            wd_cnt <= '0;
        end
    end

`ifdef PIPE_HOLD_CTRL_PERF_EN
    logic [CNT_W-1:0] perf_cnt;

    // Saturating count of cycles with any hold enable asserted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_cnt <= '0;
        end else if ((hold_pc_o | hold_if_o | hold_id_o) && perf_cnt != '1) begin
            perf_cnt <= perf_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt_o = perf_cnt;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Self-checking bench for pipe_hold_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a cycle-count based reference model.
module tb_pipe_hold_ctrl;

    localparam int unsigned DW            = 32;
    localparam int unsigned FLUSH_CYC     = 2;
    localparam int unsigned STALL_TIMEOUT = 4;
    localparam int unsigned CNT_W         = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             jump_req_i;
    logic [DW-1:0]    jump_addr_i;
    logic             hold_clint_i;
    logic             hold_ex_i;
    logic             hold_bus_i;
    logic             jump_flag_o;
    logic [DW-1:0]    jump_addr_o;
    logic             hold_pc_o;
    logic             hold_if_o;
    logic             hold_id_o;
    logic             stall_err_o;
    logic [CNT_W-1:0] stall_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int          m_flush_left;
    int          m_stall_run;
    bit          m_stalled;
    bit          m_flag, m_pc, m_if, m_id, m_err;
    logic [DW-1:0] m_addr;
    longint      m_perf;

    pipe_hold_ctrl #(
        .DW(DW), .FLUSH_CYC(FLUSH_CYC), .STALL_TIMEOUT(STALL_TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .jump_req_i(jump_req_i), .jump_addr_i(jump_addr_i),
        .hold_clint_i(hold_clint_i), .hold_ex_i(hold_ex_i), .hold_bus_i(hold_bus_i),
        .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o),
        .hold_pc_o(hold_pc_o), .hold_if_o(hold_if_o), .hold_id_o(hold_id_o),
        .stall_err_o(stall_err_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Model of one clock edge, using the input values the DUT sees at that edge.
    task automatic model_edge();
        bit prev_any;
        bit prev_stalled;
        longint perf_max;
        perf_max = (64'd1 << CNT_W) - 1;
        if (!rst) begin
            m_flush_left = 0; m_stall_run = 0; m_stalled = 0;
            m_flag = 0; m_pc = 0; m_if = 0; m_id = 0; m_err = 0;
            m_addr = '0; m_perf = 0;
            return;
        end
        prev_any     = m_pc | m_if | m_id;
        prev_stalled = m_stalled;
`ifdef PIPE_HOLD_CTRL_PERF_EN
        if (prev_any && m_perf < perf_max) m_perf++;
`endif
        m_stall_run = prev_stalled ? m_stall_run + 1 : 0;
        if (m_stall_run >= int'(STALL_TIMEOUT)) m_err = 1;
        if (jump_req_i) begin
            m_flush_left = FLUSH_CYC;
            m_flag = 1;
            m_addr = jump_addr_i;
        end else begin
            m_flag = 0;
            if (m_flush_left > 0) m_flush_left--;
        end
        if (m_flush_left > 0) begin
            m_pc = 0; m_if = 1; m_id = 1; m_stalled = 0;
        end else begin
            m_stalled = hold_clint_i | hold_ex_i | hold_bus_i;
            m_pc = m_stalled;
            m_if = m_stalled;
            m_id = hold_clint_i | hold_ex_i;
        end
    endtask

    task automatic compare_all();
        check("jump_flag", 64'(jump_flag_o), 64'(m_flag));
        check("jump_addr", 64'(jump_addr_o), 64'(m_addr));
        check("hold_pc",   64'(hold_pc_o),   64'(m_pc));
        check("hold_if",   64'(hold_if_o),   64'(m_if));
        check("hold_id",   64'(hold_id_o),   64'(m_id));
        check("stall_err", 64'(stall_err_o), 64'(m_err));
        check("stall_cnt", 64'(stall_cnt_o), 64'(m_perf));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic set_in(input bit j, input logic [DW-1:0] a, input bit c, input bit e, input bit b);
        jump_req_i = j; jump_addr_i = a; hold_clint_i = c; hold_ex_i = e; hold_bus_i = b;
    endtask

    initial begin
        rst = 1'b0;
        set_in(1, 32'hDEAD_BEEF, 0, 1, 0);
        // Reset with requests active: everything stays 0
        repeat (2) step();
        check("reset_flag", 64'(jump_flag_o), 64'd0);
        check("reset_hold_id", 64'(hold_id_o), 64'd0);
        rst = 1'b1;
        set_in(0, '0, 0, 0, 0);
        repeat (2) step();

        // Jump to 0x100, then idle
        set_in(1, 32'h0000_0100, 0, 0, 0);
        step();
        check("jump_pulse", 64'(jump_flag_o), 64'd1);
        check("jump_target", 64'(jump_addr_o), 64'h100);
        set_in(0, '0, 0, 0, 0);
        step();
        check("flush2_if", 64'(hold_if_o), 64'd1);
        repeat (3) step();

        // Bus stall, then execute busy joins
        set_in(0, '0, 0, 0, 1);
        repeat (3) step();
        set_in(0, '0, 0, 1, 1);
        step();
        check("ex_join_id", 64'(hold_id_o), 64'd1);
        set_in(0, '0, 0, 0, 0);
        repeat (2) step();

        // Jump together with a held execute busy: flush, then stall
        set_in(1, 32'h0000_2000, 0, 1, 0);
        step();
        set_in(0, '0, 0, 1, 0);
        repeat (4) step();
        check("flush_then_stall_pc", 64'(hold_pc_o), 64'd1);
        set_in(0, '0, 0, 0, 0);
        repeat (2) step();

        // Watchdog: 6-cycle execute stall with timeout 4
        rst = 1'b0; step(); rst = 1'b1;
        set_in(0, '0, 0, 1, 0);
        repeat (6) step();
        set_in(0, '0, 0, 0, 0);
        repeat (3) step();
        check("err_sticky", 64'(stall_err_o), 64'd1);
        rst = 1'b0; step(); rst = 1'b1;
        check("err_cleared", 64'(stall_err_o), 64'd0);
        step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 299) != 0);
            jump_req_i   = ($urandom_range(0, 9) == 0);
            jump_addr_i  = $urandom;
            if ($urandom_range(0, 5) == 0) hold_clint_i = ~hold_clint_i;
            if ($urandom_range(0, 5) == 0) hold_ex_i    = ~hold_ex_i;
            if ($urandom_range(0, 4) == 0) hold_bus_i   = ~hold_bus_i;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
